lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the CPU MEM stage and the data-memory bus.
- Accepts one load or store request at a time and checks it for alignment and legal funct3.
- Runs a request/ack bus transaction with timeout, generates store byte-enables and lane-replicated write data, and returns sign/zero-extended load data.
- Drives the pipeline stall while a transaction is outstanding.

---
 rtl/lsu_mem_ctrl_pkg.sv | 37 +++
 rtl/lsu_store_aligner.sv | 30 +++
 rtl/lsu_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and the request legality check used when a request is accepted.
package lsu_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } lsu_state_e;

    // True when the request must be rejected without touching the bus.
    function automatic logic req_is_bad(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_store_aligner.sv
// Store lane steering: byte enables and lane-replicated write data for
// SB/SH/SW, derived from funct3 and the low address bits.
module lsu_store_aligner
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory bus: checks
// requests, runs one request/ack transaction with timeout, extends load data.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_misaligned,
    output logic        exc_bus,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q;
    logic [7:0]  timer_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] wdata_q;
    logic        mem_req_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        exc_mis_q;
    logic        exc_bus_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] load_ext_d;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    lsu_store_aligner u_store_aligner (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .be_o      (st_be),
        .wdata_o   (st_wdata)
    );

    always_comb begin
        load_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_ext_d = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_ext_d = {24'd0, load_byte};
            F3_H:    load_ext_d = {{16{load_half[15]}}, load_half};
            F3_HU:   load_ext_d = {16'd0, load_half};
            default: load_ext_d = mem_rdata;
        endcase
    end

    // Response fields are pulses: they default low and are set only on the
    // edge that enters RESP or ERR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            is_store_q   <= 1'b0;
            wdata_q      <= 32'd0;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            exc_mis_q    <= 1'b0;
            exc_bus_q    <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            exc_mis_q    <= 1'b0;
            exc_bus_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_is_bad(req_is_store, req_funct3, req_addr[1:0])) begin
                            state_q      <= ERR;
                            resp_valid_q <= 1'b1;
                            exc_mis_q    <= 1'b1;
                        end else begin
                            state_q    <= BUS;
                            addr_q     <= req_addr;
                            funct3_q   <= req_funct3;
                            is_store_q <= req_is_store;
                            wdata_q    <= req_wdata;
                            timer_q    <= 8'd0;
                            mem_req_q  <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= is_store_q ? 32'd0 : load_ext_d;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q      <= ERR;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        exc_bus_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus        = exc_bus_q;
    assign stall          = req_valid & ~resp_valid_q;

    // Bus fields come only from latched request state and are zero off-bus.
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & is_store_q;
    assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = !mem_req_q ? 4'b0000 : (is_store_q ? st_be : 4'b1111);
    assign mem_wdata = (mem_req_q & is_store_q) ? st_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_misaligned;
    logic        exc_bus;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .exc_misaligned (exc_misaligned),
        .exc_bus        (exc_bus),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    // Reference model: what a single access should produce, from the ISA rules.
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] addr, wdata, rdata,
                                  output logic bad, we, output logic [3:0] be,
                                  output logic [31:0] wd, rd);
        int size;
        int off;
        logic legal;
        logic [31:0] v;
        size  = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        bad   = !legal || (addr % size != 0);
        off   = int'(addr % 4);
        rd    = 32'd0;
        if (st) begin
            we = 1'b1;
            if (size == 1) begin
                be = 4'(1 << off);
                wd = {24'd0, wdata[7:0]} * 32'h01010101;
            end else if (size == 2) begin
                be = 4'(3 << off);
                wd = {16'd0, wdata[15:0]} * 32'h00010001;
            end else begin
                be = 4'hF;
                wd = wdata;
            end
        end else begin
            we = 1'b0;
            be = 4'hF;
            wd = 32'd0;
            v  = rdata >> (off * 8);
            if (size == 1) begin
                rd = v & 32'hFF;
                if (f3 < 3'd4 && rd >= 32'd128) rd = rd - 32'd256;
            end else if (size == 2) begin
                rd = v & 32'hFFFF;
                if (f3 < 3'd4 && rd >= 32'd32768) rd = rd - 32'd65536;
            end else begin
                rd = rdata;
            end
        end
    endfunction

    // Drives one request held until its response; ack_wait = BUS cycles before ack.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, wd_in, rdata,
                                 input int ack_wait,
                                 output int lat, output int reqc,
                                 output logic [31:0] rd, output logic mis, bus, we,
                                 output logic [3:0] be, output logic [31:0] wd, maddr,
                                 output logic stable, stall_ok, ready_ok);
        lat = -1; reqc = 0; rd = 32'd0; mis = 1'b0; bus = 1'b0; we = 1'b0;
        be = 4'd0; wd = 32'd0; maddr = 32'd0; stable = 1'b1; stall_ok = 1'b1;
        ready_ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd_in; mem_ack = 1'b0; mem_rdata = rdata;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = c; rd = resp_rdata; mis = exc_misaligned; bus = exc_bus;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (mem_req === 1'b1) begin
                if (reqc == 0) begin
                    we = mem_we; be = mem_be; wd = mem_wdata; maddr = mem_addr;
                end else if (mem_we !== we || mem_be !== be || mem_wdata !== wd || mem_addr !== maddr) begin
                    stable = 1'b0;
                end
                if (reqc == ack_wait) mem_ack = 1'b1;
                reqc++;
            end
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #3;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin n_fail++; $display("[TB] FAIL reset_bus_fields: got we=%b be=%b addr=%h wd=%h want all 0", mem_we, mem_be, mem_addr, mem_wdata); end
        n_cmp++; if ({resp_rdata, exc_misaligned, exc_bus, stall} !== 35'd0) begin n_fail++; $display("[TB] FAIL reset_resp_fields: got rd=%h mis=%b bus=%b stall=%b want all 0", resp_rdata, exc_misaligned, exc_bus, stall); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int lat, reqc; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL lw_latency: got %0d want 2", lat); end
        n_cmp++; if (ma !== 32'h100) begin n_fail++; $display("[TB] FAIL lw_mem_addr: got %h want 00000100", ma); end
        n_cmp++; if (be !== 4'b1111 || we !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_be_we: got be=%b we=%b want be=1111 we=0", be, we); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_rdata: got %h want deadbeef", rd); end
        n_cmp++; if (rok !== 1'b1 || sok !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_ready_stall: got ready=%b stall_ok=%b want 1 1", rok, sok); end
    endtask

    task automatic test_lb();
        int lat, reqc; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        applyStimulus(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF0011, 0, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb_rdata: got %h want ffffff80", rd); end
        n_cmp++; if (ma !== 32'h200) begin n_fail++; $display("[TB] FAIL lb_mem_addr: got %h want 00000200", ma); end
        applyStimulus(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF0011, 0, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (rd !== 32'h00000080) begin n_fail++; $display("[TB] FAIL lbu_rdata: got %h want 00000080", rd); end
    endtask

    task automatic test_sh_wait();
        int lat, reqc; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        applyStimulus(1'b1, 3'd1, 32'h302, 32'h1234ABCD, 32'h55555555, 3, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (be !== 4'b1100 || wd !== 32'hABCDABCD || we !== 1'b1) begin n_fail++; $display("[TB] FAIL sh_bus_fields: got be=%b wd=%h we=%b want 1100 abcdabcd 1", be, wd, we); end
        n_cmp++; if (reqc !== 4 || stb !== 1'b1) begin n_fail++; $display("[TB] FAIL sh_req_held: got cycles=%0d stable=%b want 4 1", reqc, stb); end
        n_cmp++; if (sok !== 1'b1) begin n_fail++; $display("[TB] FAIL sh_stall: got stall_ok=%b want 1", sok); end
        n_cmp++; if (rd !== 32'd0 || lat !== 5 || mis !== 1'b0 || bus !== 1'b0) begin n_fail++; $display("[TB] FAIL sh_resp: got rd=%h lat=%0d mis=%b bus=%b want 0 5 0 0", rd, lat, mis, bus); end
    endtask

    task automatic test_misaligned();
        int lat, reqc; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 0, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (lat !== 1 || reqc !== 0) begin n_fail++; $display("[TB] FAIL mis_lw_timing: got lat=%0d req_cycles=%0d want 1 0", lat, reqc); end
        n_cmp++; if (mis !== 1'b1 || bus !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("[TB] FAIL mis_lw_flags: got mis=%b bus=%b rd=%h want 1 0 0", mis, bus, rd); end
        applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 32'h12345678, 0, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (lat !== 1 || reqc !== 0 || mis !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_f3: got lat=%0d req_cycles=%0d mis=%b want 1 0 1", lat, reqc, mis); end
    endtask

    task automatic test_timeout();
        int lat, reqc; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        applyStimulus(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFEF00D, 1000, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
        n_cmp++; if (reqc !== 16) begin n_fail++; $display("[TB] FAIL timeout_req_cycles: got %0d want 16", reqc); end
        n_cmp++; if (bus !== 1'b1 || mis !== 1'b0 || rd !== 32'd0 || lat !== 17) begin n_fail++; $display("[TB] FAIL timeout_resp: got bus=%b mis=%b rd=%h lat=%0d want 1 0 0 17", bus, mis, rd, lat); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_idle: got ready=%b want 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        logic saw_resp, saw_req;
        saw_resp = 1'b0; saw_req = 1'b0;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_in_bus: got mem_req=%b want 1", mem_req); end
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_async: got mem_req=%b ready=%b want 0 1", mem_req, req_ready); end
        req_valid = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (resp_valid !== 1'b0) saw_resp = 1'b1;
            if (mem_req !== 1'b0) saw_req = 1'b1;
        end
        n_cmp++; if (saw_resp !== 1'b0 || saw_req !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_late_ack: got resp=%b req=%b ready=%b want 0 0 1", saw_resp, saw_req, req_ready); end
    endtask

    task automatic test_random();
        int lat, reqc, aw; logic [31:0] rd, wd, ma; logic mis, bus, we, stb, sok, rok; logic [3:0] be;
        logic st; logic [2:0] f3; logic [31:0] addr, wdin, rdata;
        logic e_bad, e_we; logic [3:0] e_be; logic [31:0] e_wd, e_rd;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom); f3 = 3'($urandom);
            addr = $urandom; wdin = $urandom; rdata = $urandom;
            aw = int'($urandom_range(0, 4));
            model(st, f3, addr, wdin, rdata, e_bad, e_we, e_be, e_wd, e_rd);
            applyStimulus(st, f3, addr, wdin, rdata, aw, lat, reqc, rd, mis, bus, we, be, wd, ma, stb, sok, rok);
            n_cmp++; if (mis !== e_bad || bus !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_exc[%0d]: got mis=%b bus=%b want %b 0", i, mis, bus, e_bad); end
            n_cmp++; if (sok !== 1'b1 || rok !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd_stall_ready[%0d]: got stall_ok=%b ready=%b want 1 1", i, sok, rok); end
            if (e_bad) begin
                n_cmp++; if (lat !== 1 || reqc !== 0 || rd !== 32'd0) begin n_fail++; $display("[TB] FAIL rnd_bad[%0d]: got lat=%0d req_cycles=%0d rd=%h want 1 0 0", i, lat, reqc, rd); end
            end else begin
                n_cmp++; if (lat !== aw + 2 || reqc !== aw + 1 || stb !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd_timing[%0d]: got lat=%0d req_cycles=%0d stable=%b want %0d %0d 1", i, lat, reqc, stb, aw + 2, aw + 1); end
                n_cmp++; if (ma !== {addr[31:2], 2'b00} || we !== e_we || be !== e_be || wd !== e_wd) begin n_fail++; $display("[TB] FAIL rnd_bus[%0d]: got addr=%h we=%b be=%b wd=%h want %h %b %b %h", i, ma, we, be, wd, {addr[31:2], 2'b00}, e_we, e_be, e_wd); end
                n_cmp++; if (rd !== e_rd) begin n_fail++; $display("[TB] FAIL rnd_rdata[%0d]: got %h want %h (f3=%0d addr=%h mem=%h)", i, rd, e_rd, f3, addr, rdata); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
